// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory: access-size
// encodings, controller states and the store byte-enable helper.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dm_state_e;

    // Byte-enable mask for a store of the given size at the given lane.
    // Misaligned combinations are rejected elsewhere before this is used.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_ram_bytelane_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface dm_ram_bytelane_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  Req_Valid;
    logic                  Req_Ready;
    logic                  Mem_Write;
    logic [1:0]            Mem_Size;
    logic                  Mem_Unsigned;
    logic [ADDR_WIDTH-1:0] DM_Addr;
    logic [31:0]           M_W_Data;
    logic                  Rsp_Valid;
    logic [31:0]           M_R_Data;
    logic                  Mem_Err;

    // Requester side (pipeline MEM stage)
    modport master (
        output Req_Valid, Mem_Write, Mem_Size, Mem_Unsigned, DM_Addr, M_W_Data,
        input  Req_Ready, Rsp_Valid, M_R_Data, Mem_Err
    );

    // Memory side
    modport slave (
        input  Req_Valid, Mem_Write, Mem_Size, Mem_Unsigned, DM_Addr, M_W_Data,
        output Req_Ready, Rsp_Valid, M_R_Data, Mem_Err
    );
endinterface

// File: rtl/dm_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or
// zero-extends it to 32 bits.
module dm_load_extend
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension according to access size
    always_comb begin
        byte_sel = 8'h00;
        case (lane_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SZ_WORD: data_o = word_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_ram_bytelane.sv
// Byte-lane data memory for the MEM stage: valid/ready request port,
// registered single-cycle response, error reporting and an optional
// post-reset clear walk that zeroes every word.
module dm_ram_bytelane
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH_WORDS    = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk_dm,
    input  logic                 rst_dm,
    dm_ram_bytelane_if.slave     bus
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W:0]    DEPTH_L   = (IDX_W + 1)'(DEPTH_WORDS);
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH_WORDS - 1);

    // Controller state
    dm_state_e         state_q, state_d;
    logic [MEM_AW-1:0] clr_ptr_q, clr_ptr_d;
    logic              clr_we;

    // Request decode
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [MEM_AW-1:0] mem_addr;
    logic              req_err;
    logic              accept;

    // Single write port and read strobe shared by clear walk and requests
    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              rd_en;
    logic [31:0]       rd_word;

    // Response register
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic [1:0]        rsp_lane_q;
    logic [1:0]        rsp_size_q;
    logic              rsp_uns_q;
    logic [31:0]       load_data;

    assign word_idx = bus.DM_Addr[ADDR_WIDTH-1:2];
    assign lane     = bus.DM_Addr[1:0];
    assign mem_addr = word_idx[MEM_AW-1:0];

    // A request arriving in the reset cycle is never taken
    assign accept   = bus.Req_Valid && bus.Req_Ready && !rst_dm;

    // Alignment, size and range checks for the presented request
    always_comb begin
        req_err = 1'b0;
        case (bus.Mem_Size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.DM_Addr[0];
            SZ_WORD: req_err = |lane;
            default: req_err = 1'b1;
        endcase
        if ({1'b0, word_idx} >= DEPTH_L) begin
            req_err = 1'b1;
        end
    end

    // State register and clear pointer
    always_ff @(posedge clk_dm) begin
        if (rst_dm) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: CLEAR zeroes one word per cycle (or leaves at once when
    // clearing is disabled); RUN accepts a request every cycle
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = (CLEAR_ON_RESET != 0);
                clr_ptr_d = clr_ptr_q + 1'b1;
                if ((CLEAR_ON_RESET == 0) || (clr_ptr_q == LAST_WORD)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    // Write-port and read-strobe steering; erroring requests touch nothing
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = mem_addr;
        wr_be   = 4'b0000;
        wr_data = 32'h0000_0000;
        if (clr_we && !rst_dm) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr_q;
            wr_be   = 4'b1111;
        end else if (accept && bus.Mem_Write && !req_err) begin
            wr_en   = 1'b1;
            wr_be   = byte_enable(bus.Mem_Size, lane);
            wr_data = bus.M_W_Data << {lane, 3'b000};
        end
        rd_en = accept && !bus.Mem_Write && !req_err;
    end

    // One byte-wide array per lane gives a true byte-enable write with a
    // registered read, without any read-modify-write
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_byte_q;

        // Byte write on enable, registered read on load acceptance
        always_ff @(posedge clk_dm) begin
            if (wr_en && wr_be[gi]) begin
                mem_q[wr_addr] <= wr_data[gi*8 +: 8];
            end
            if (rd_en) begin
                rd_byte_q <= mem_q[mem_addr];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_byte_q;
    end

    // Response pipeline: one pulse per accepted request, dropped by reset
    always_ff @(posedge clk_dm) begin
        if (rst_dm) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_lane_q  <= 2'b00;
            rsp_size_q  <= 2'b00;
            rsp_uns_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q  <= req_err;
                rsp_load_q <= !bus.Mem_Write;
                rsp_lane_q <= lane;
                rsp_size_q <= bus.Mem_Size;
                rsp_uns_q  <= bus.Mem_Unsigned;
            end
        end
    end

    dm_load_extend u_load_extend (
        .word_i     (rd_word),
        .lane_i     (rsp_lane_q),
        .size_i     (rsp_size_q),
        .unsigned_i (rsp_uns_q),
        .data_o     (load_data)
    );

    assign bus.Req_Ready = (state_q == ST_RUN);
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Mem_Err   = rsp_valid_q & rsp_err_q;
    assign bus.M_R_Data  = (rsp_valid_q && rsp_load_q && !rsp_err_q) ? load_data : 32'h0000_0000;

endmodule
